// File: rtl/iob_cache_mem_arbiter.sv
// iob_cache_mem_arbiter
//   Shares one native back-end memory port between N_MASTERS cache back-ends.
//   Round-robin arbitration with one transaction per grant. An optional
//   per-master lock keeps a burst contiguous for at most MAX_LOCK
//   transactions. Memory-side request outputs are registered.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   m_valid    per-master request, held until the matching m_ready
//   m_addr     master i address at [i*ADDR_W +: ADDR_W]
//   m_wdata    master i write data at [i*DATA_W +: DATA_W]
//   m_wstrb    master i byte strobes (all zero = read)
//   m_lock     master i asks to keep the grant after its current transaction
//   m_rdata    read data broadcast to all masters (valid with m_ready)
//   m_ready    one-hot completion pulse to the granted master
//   mem_valid  registered memory request
//   mem_addr   registered address
//   mem_wdata  registered write data
//   mem_wstrb  registered byte strobes
//   mem_rdata  memory read data
//   mem_ready  memory completion pulse
//   grant      index of the current or last granted master
//   busy       a transaction is outstanding (same as mem_valid)
module iob_cache_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_LOCK  = 8,
  parameter int M_W       = $clog2(N_MASTERS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  input  logic [N_MASTERS-1:0]            m_lock,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            mem_valid,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_wstrb,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic                            mem_ready,
  output logic [M_W-1:0]                  grant,
  output logic                            busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LCW    = $clog2(MAX_LOCK) + 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);
  localparam logic [M_W-1:0] LAST_M    = M_W'(N_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_n;
  logic [M_W-1:0]      rr_ptr, rr_ptr_n;
  logic [M_W-1:0]      grant_n;
  logic [LCW-1:0]      lock_cnt, lock_cnt_n;
  logic                lock_active, lock_active_n;
  logic                mem_valid_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic [NBYTES-1:0]   mem_wstrb_n;

  logic                win;
  logic [M_W-1:0]      win_idx;
  int unsigned         idx;

  assign m_rdata = mem_rdata;
  assign busy    = mem_valid;

  // Winner selection. A held lock restricts eligibility to the locked
  // master; otherwise search starting at rr_ptr. A lock whose owner has
  // dropped m_lock falls straight through to round-robin.
  always_comb begin
    win     = 1'b0;
    win_idx = grant;
    idx     = 0;
    if (lock_active && m_lock[grant]) begin
      win     = m_valid[grant];
      win_idx = grant;
    end else begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        idx = (int'(rr_ptr) + i) % N_MASTERS;
        if (!win && m_valid[idx]) begin
          win     = 1'b1;
          win_idx = M_W'(idx);
        end
      end
    end
  end

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    grant_n       = grant;
    lock_cnt_n    = lock_cnt;
    lock_active_n = lock_active;
    mem_valid_n   = mem_valid;
    mem_addr_n    = mem_addr;
    mem_wdata_n   = mem_wdata;
    mem_wstrb_n   = mem_wstrb;
    m_ready       = '0;
    case (state)
      IDLE: begin
        if (lock_active && !m_lock[grant]) begin
          lock_active_n = 1'b0;
          lock_cnt_n    = '0;
        end
        if (win) begin
          grant_n     = win_idx;
          mem_addr_n  = m_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_wdata_n = m_wdata[int'(win_idx)*DATA_W +: DATA_W];
          mem_wstrb_n = m_wstrb[int'(win_idx)*NBYTES +: NBYTES];
          mem_valid_n = 1'b1;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          m_ready[grant] = 1'b1;
          mem_valid_n    = 1'b0;
          state_n        = IDLE;
          // MAX_LOCK=1 makes LOCK_LAST zero, so the lock never engages.
          if (m_lock[grant] && lock_cnt < LOCK_LAST) begin
            lock_active_n = 1'b1;
            lock_cnt_n    = lock_cnt + LCW'(1);
          end else begin
            lock_active_n = 1'b0;
            lock_cnt_n    = '0;
            rr_ptr_n      = (grant == LAST_M) ? '0 : grant + M_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      lock_cnt    <= '0;
      lock_active <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      grant       <= grant_n;
      lock_cnt    <= lock_cnt_n;
      lock_active <= lock_active_n;
      mem_valid   <= mem_valid_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      mem_wstrb   <= mem_wstrb_n;
    end
  end

endmodule

// File: doc/iob_cache_mem_arbiter.md
Name: iob_cache_mem_arbiter

Overview:
- Shares one back-end native memory port (mem_valid/addr/wdata/wstrb/rdata/ready) between N_MASTERS cache back-ends, e.g. I-cache and D-cache instances of iob_cache.
- Round-robin arbitration, one transaction per grant.
- An optional per-master lock keeps a line-fill or line-write-back burst contiguous, bounded by MAX_LOCK to prevent starvation.
- Memory-side request outputs are registered.

Parameters:
- N_MASTERS, 2, number of requesting back-ends (≥2).
- ADDR_W, 12, native address width (same as BE_ADDR_W of the caches).
- DATA_W, 32, native data width (BE_DATA_W); NBYTES = DATA_W/8.
- MAX_LOCK, 8, maximum consecutive transactions one master may hold under lock (≥1).
- M_W, $clog2(N_MASTERS), grant index width (derived, do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_valid  in  N_MASTERS  per-master request; held high until the matching m_ready.
- m_addr  in  N_MASTERS*ADDR_W  master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  master i write data.
- m_wstrb  in  N_MASTERS*NBYTES  master i byte strobes; 0 means read.
- m_lock  in  N_MASTERS  master i requests to keep the grant after its current transaction.
- m_rdata  out  DATA_W  read data, broadcast to all masters.
- m_ready  out  N_MASTERS  one-hot completion pulse to the granted master.
- mem_valid  out  1  registered request to memory.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_wstrb  out  NBYTES  registered strobes.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion, single-cycle pulse.
- grant  out  M_W  index of the current or last granted master (debug).
- busy  out  1  a transaction is outstanding (equals mem_valid).

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - mem_valid, busy, mem_addr, mem_wdata, mem_wstrb, grant, rr_ptr, lock_cnt and lock_active all 0.
  - m_ready is 0.
  - Reset asserted mid-transaction aborts it with no m_ready. Masters and memory are reset in the same domain.
- States: IDLE, BUSY.
- IDLE arbitration (combinational, registered at the edge):
  - If lock_active and m_lock[grant]: only master `grant` is eligible. If its m_valid=0, stay IDLE and do not grant others.
  - If lock_active and m_lock[grant]=0: lock_active is cleared this cycle and normal round-robin applies in the same cycle.
  - Normal round-robin: the first i with m_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo N_MASTERS.
  - On a winner: latch grant, mem_addr, mem_wdata and mem_wstrb from that master; set mem_valid=1; go to BUSY.
  - Request-to-mem_valid latency is 1 cycle.
- BUSY:
  - mem_* are held stable until mem_ready.
  - m_ready[grant] = mem_ready (combinational, same cycle). All other m_ready bits are 0.
  - m_rdata = mem_rdata at all times. It is valid only while m_ready is high.
- On the mem_ready edge, mem_valid goes to 0 and the state returns to IDLE. This gives a minimum 1-cycle bubble between transactions.
- Lock bookkeeping on that edge:
  - If m_lock[grant]=1 and lock_cnt < MAX_LOCK-1: lock_active=1, lock_cnt+1, rr_ptr unchanged.
  - Otherwise: lock_active=0, lock_cnt=0, rr_ptr = grant+1, wrapping to 0 after N_MASTERS-1.
- MAX_LOCK=1 disables locking entirely.
- m_valid falling before m_ready is a protocol violation. The transaction already issued still completes, and m_ready is still pulsed.
- mem_ready while IDLE is ignored; m_ready stays 0.
- Requests arriving during BUSY wait. No queueing beyond the masters' held valid.
- Simultaneous mem_ready and a new m_valid from the same master: the new request is arbitrated in the following IDLE cycle.

Test Plan:
- Reset, then m_valid=2'b01, m_addr[0]=0x100, wstrb=0; mem_ready one cycle after mem_valid, mem_rdata=0xDEADBEEF.
  - Expect mem_valid 1 cycle after the request, mem_addr=0x100.
  - Expect m_ready=2'b01 with m_rdata=0xDEADBEEF; mem_valid=0 next cycle.
- Both masters hold m_valid continuously, no lock.
  - Expect grants 0,1,0,1, each separated by one IDLE cycle; rr_ptr alternates.
- Master 0 holds m_lock=1 for 4 writes (addr 0x200..0x20C, wstrb=4'hF) while master 1 requests throughout.
  - Expect four consecutive master-0 grants, then master 1.
  - mem_wdata/mem_wstrb must match each beat.
- MAX_LOCK=8, master 0 locks indefinitely, master 1 requesting.
  - Expect exactly 8 master-0 grants, then master 1 is granted.
- Locked master 0 drops m_valid while m_lock stays 1, master 1 requesting.
  - Expect no grant; IDLE held.
  - Deassert m_lock: master 1 is granted on the next edge.
- Assert reset mid-BUSY (mem_valid=1).
  - Expect mem_valid=0, grant=0 immediately with no clock.
  - Expect no m_ready pulse; after release, arbitration restarts from master 0.
